// File: rtl/branch_unit.sv
// branch_unit
//   Branch resolution unit at the ID/EX boundary. It decodes the MIPS branch
//   group, compares the operands as signed values and forms the target and link
//   address. The outcome is registered for the redirect logic. It also keeps a
//   2-bit saturating branch history table for the fetch stage and saturating
//   statistics counters.
//
// Parameters
//   WIDTH      data/address width (>= 16)
//   BHT_DEPTH  number of history entries (power of two, >= 2)
//   CNT_W      width of the statistics counters
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   lookup_pc/pred_taken  fetch-side prediction lookup (combinational)
//   valid_in, ins, pc     branch candidate: instruction word and its address
//   din_a, din_b          forwarded rs/rt operand values
//   pred_in               prediction made at fetch for this branch
//   stall, flush          hold everything / kill the current input
//   clear_stats           zero both statistics counters
//   res_valid, branch, target, link, link_addr, mispredict, redirect_pc
//                         registered resolution results
//   br_cnt, mp_cnt        resolved-branch and misprediction counters
module branch_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_taken,
  input  logic             valid_in,
  input  logic [31:0]      ins,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             pred_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             clear_stats,
  output logic             res_valid,
  output logic             branch,
  output logic [WIDTH-1:0] target,
  output logic             link,
  output logic [WIDTH-1:0] link_addr,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [5:0]       op;
  logic [4:0]       rt;
  logic [15:0]      imm;
  logic             a_neg;
  logic             a_zero;
  logic             a_eq_b;
  logic             is_branch;
  logic             taken;
  logic             is_link;
  logic             accept;
  logic [WIDTH+17:0] offset_ext;
  logic [WIDTH-1:0] next_target;
  logic [WIDTH-1:0] next_link_addr;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [1:0]       bht [BHT_DEPTH];

  assign op     = ins[31:26];
  assign rt     = ins[20:16];
  assign imm    = ins[15:0];
  assign a_neg  = din_a[WIDTH-1];
  assign a_zero = (din_a == '0);
  assign a_eq_b = (din_a == din_b);

  // Decode the branch group and evaluate its condition with din_a as signed.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    is_link   = 1'b0;
    case (op)
      6'b000100: begin is_branch = 1'b1; taken = a_eq_b;           end
      6'b000101: begin is_branch = 1'b1; taken = ~a_eq_b;          end
      6'b000111: begin is_branch = 1'b1; taken = ~a_neg & ~a_zero; end
      6'b000110: begin is_branch = 1'b1; taken = a_neg | a_zero;   end
      6'b000001: begin
        case (rt)
          5'b00000: begin is_branch = 1'b1; taken = a_neg;  end
          5'b00001: begin is_branch = 1'b1; taken = ~a_neg; end
          5'b10000: begin is_branch = 1'b1; taken = a_neg;  is_link = 1'b1; end
          5'b10001: begin is_branch = 1'b1; taken = ~a_neg; is_link = 1'b1; end
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  // The sign extension is built wider than WIDTH so it also works when WIDTH
  // is narrower than the shifted 18-bit offset; the low WIDTH bits are used.
  assign offset_ext     = {{WIDTH{imm[15]}}, imm, 2'b00};
  assign next_target    = pc + WIDTH'(4) + offset_ext[WIDTH-1:0];
  assign next_link_addr = pc + WIDTH'(8);

  assign accept     = valid_in & is_branch & ~stall & ~flush;
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign update_idx = pc[IDX_W+1:2];

  // The lookup reads the table before this cycle's update, so a same-index
  // update only becomes visible one cycle later.
  assign pred_taken = bht[lookup_idx][1];

  // Result registers. Flush outranks stall for clearing res_valid. A
  // non-branch or an idle cycle drops res_valid so that each result is a
  // one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      branch      <= 1'b0;
      target      <= '0;
      link        <= 1'b0;
      link_addr   <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (!stall) begin
      res_valid <= valid_in & is_branch;
      if (accept) begin
        branch      <= taken;
        target      <= next_target;
        link        <= is_link;
        link_addr   <= next_link_addr;
        mispredict  <= (pred_in != taken);
        redirect_pc <= taken ? next_target : next_link_addr;
      end
    end
  end

  // Two-bit saturating history update at the resolving branch's index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accept) begin
      if (taken && bht[update_idx] != 2'b11)
        bht[update_idx] <= bht[update_idx] + 2'b01;
      else if (!taken && bht[update_idx] != 2'b00)
        bht[update_idx] <= bht[update_idx] - 2'b01;
    end
  end

  // Statistics counters saturate at all-ones. clear_stats is an explicit
  // command, so it wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (clear_stats) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (accept) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if ((pred_in != taken) && mp_cnt != '1) mp_cnt <= mp_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit
//   Directed bench for branch_unit (WIDTH=32, BHT_DEPTH=16, CNT_W=4). A table
//   of hand-computed vectors is applied back to back. Short hand-written
//   sequences then cover reset, stall/flush, counter saturation and the
//   history table.
module tb_branch_unit;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        rv;
    logic        br;
    logic        lk;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] la;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        valid_in;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] din_a;
  logic [31:0] din_b;
  logic        pred_in;
  logic        stall;
  logic        flush;
  logic        clear_stats;
  logic        res_valid;
  logic        branch;
  logic [31:0] target;
  logic        link;
  logic [31:0] link_addr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  br_cnt;
  logic [3:0]  mp_cnt;

  int errors = 0;
  int checks = 0;
  int exp_br = 0;
  int exp_mp = 0;
  logic [1:0] bht_model;
  vec_t tbl [14];

  branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .valid_in(valid_in), .ins(ins), .pc(pc), .din_a(din_a), .din_b(din_b),
    .pred_in(pred_in), .stall(stall), .flush(flush), .clear_stats(clear_stats),
    .res_valid(res_valid), .branch(branch), .target(target), .link(link),
    .link_addr(link_addr), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  // Free-running clock with a long period so combinational lookups can be
  // swept inside one phase.
  always #50 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic pr);
    ins      = i;
    pc       = p;
    din_a    = a;
    din_b    = b;
    pred_in  = pr;
    valid_in = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference saturating counter for CNT_W=4.
  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  initial begin
    // Opcode/rt constants used throughout.
    tbl[0]  = '{mk(6'b000100, 5'd0, 16'hFFFC), 32'h00400010, 32'd5, 32'd5, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b1, 32'h00400004, 32'h00400018, 32'h00400004};
    tbl[1]  = '{mk(6'b000100, 5'd0, 16'h0010), 32'h00400020, 32'd5, 32'd6, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h00400064, 32'h00400028, 32'h00400028};
    tbl[2]  = '{mk(6'b000101, 5'd0, 16'h0001), 32'h00001000, 32'd1, 32'd2, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h00001008, 32'h00001008, 32'h00001008};
    tbl[3]  = '{mk(6'b000111, 5'd0, 16'h0008), 32'h00002000, 32'h80000000, 32'd0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 32'h00002024, 32'h00002008, 32'h00002008};
    tbl[4]  = '{mk(6'b000111, 5'd0, 16'h0002), 32'h00002010, 32'd1, 32'd0, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h0000201C, 32'h00002018, 32'h0000201C};
    tbl[5]  = '{mk(6'b000110, 5'd0, 16'hFFFF), 32'h00003000, 32'd0, 32'd9, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b1, 32'h00003000, 32'h00003008, 32'h00003000};
    tbl[6]  = '{mk(6'b000001, 5'b00000, 16'h0004), 32'h00003010, 32'h7FFFFFFF, 32'd0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h00003024, 32'h00003018, 32'h00003018};
    tbl[7]  = '{mk(6'b000001, 5'b00001, 16'h0004), 32'h00003020, 32'd0, 32'd0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b1, 32'h00003034, 32'h00003028, 32'h00003034};
    tbl[8]  = '{mk(6'b000001, 5'b10000, 16'h0003), 32'h00400100, 32'hFFFFFFFF, 32'd0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 32'h00400110, 32'h00400108, 32'h00400110};
    tbl[9]  = '{mk(6'b000001, 5'b10001, 16'h0001), 32'h00004000, 32'h80000000, 32'd0, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h00004008, 32'h00004008, 32'h00004008};
    tbl[10] = '{mk(6'b000100, 5'd0, 16'h0000), 32'hFFFFFFF8, 32'd3, 32'd3, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC};
    tbl[11] = '{mk(6'b000001, 5'b00010, 16'h0004), 32'h00005000, 32'hFFFFFFFF, 32'd0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[12] = '{mk(6'b000000, 5'd0, 16'h0004), 32'h00005010, 32'd1, 32'd1, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[13] = '{mk(6'b000101, 5'd0, 16'h8000), 32'h00006000, 32'd7, 32'd7, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFE6004, 32'h00006008, 32'h00006008};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; clear_stats = 1'b0;
    lookup_pc = 32'h0; valid_in = 1'b0;
    applyStimulus(mk(6'b000100, 5'd0, 16'h0004), 32'h00000100, 32'd1, 32'd1, 1'b0);

    // Reset held for two edges with a valid BEQ present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_branch", 32'(branch), 32'h0);
    checkOutput("rst_target", target, 32'h0);
    checkOutput("rst_link", 32'(link), 32'h0);
    checkOutput("rst_link_addr", link_addr, 32'h0);
    checkOutput("rst_mispredict", 32'(mispredict), 32'h0);
    checkOutput("rst_redirect", redirect_pc, 32'h0);
    checkOutput("rst_br_cnt", 32'(br_cnt), 32'h0);
    checkOutput("rst_mp_cnt", 32'(mp_cnt), 32'h0);
    for (int k = 0; k < 16; k++) begin
      lookup_pc = 32'(k * 4);
      #1;
      checkOutput("rst_pred_taken", 32'(pred_taken), 32'h0);
    end
    lookup_pc = 32'h0;
    rst_n = 1'b1;

    // Table vectors, one per cycle with no gap.
    for (int v = 0; v < 14; v++) begin
      applyStimulus(tbl[v].ins, tbl[v].pc, tbl[v].a, tbl[v].b, tbl[v].pred);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("v%0d_res_valid", v), 32'(res_valid), 32'(tbl[v].rv));
      if (tbl[v].rv) begin
        exp_br = sat_inc(exp_br);
        if (tbl[v].mis) exp_mp = sat_inc(exp_mp);
        checkOutput($sformatf("v%0d_branch", v), 32'(branch), 32'(tbl[v].br));
        checkOutput($sformatf("v%0d_target", v), target, tbl[v].tgt);
        checkOutput($sformatf("v%0d_link", v), 32'(link), 32'(tbl[v].lk));
        checkOutput($sformatf("v%0d_link_addr", v), link_addr, tbl[v].la);
        checkOutput($sformatf("v%0d_mispredict", v), 32'(mispredict), 32'(tbl[v].mis));
        checkOutput($sformatf("v%0d_redirect", v), redirect_pc, tbl[v].rd);
      end
      checkOutput($sformatf("v%0d_br_cnt", v), 32'(br_cnt), 32'(exp_br));
      checkOutput($sformatf("v%0d_mp_cnt", v), 32'(mp_cnt), 32'(exp_mp));
    end

    // Stall for three cycles with a new taken branch waiting: everything holds.
    stall = 1'b1;
    applyStimulus(mk(6'b000100, 5'd0, 16'h0001), 32'h00007000, 32'd2, 32'd2, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_res_valid", 32'(res_valid), 32'h1);
      checkOutput("stall_branch", 32'(branch), 32'h0);
      checkOutput("stall_redirect", redirect_pc, 32'h00006008);
      checkOutput("stall_br_cnt", 32'(br_cnt), 32'(exp_br));
      checkOutput("stall_mp_cnt", 32'(mp_cnt), 32'(exp_mp));
    end

    // Flush together with stall and a valid taken BNE.
    flush = 1'b1;
    applyStimulus(mk(6'b000101, 5'd0, 16'h0001), 32'h00007100, 32'd1, 32'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("flush_res_valid", 32'(res_valid), 32'h0);
    checkOutput("flush_br_cnt", 32'(br_cnt), 32'(exp_br));
    checkOutput("flush_redirect", redirect_pc, 32'h00006008);
    flush = 1'b0;
    stall = 1'b0;

    // Clear, then 17 taken branches mispredicted as not-taken: both saturate.
    valid_in = 1'b0;
    clear_stats = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_stats = 1'b0;
    checkOutput("clear_br_cnt", 32'(br_cnt), 32'h0);
    checkOutput("clear_mp_cnt", 32'(mp_cnt), 32'h0);
    for (int n = 0; n < 17; n++) begin
      applyStimulus(mk(6'b000100, 5'd0, 16'h0002), 32'h00000100, 32'd4, 32'd4, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    checkOutput("sat_br_cnt", 32'(br_cnt), 32'd15);
    checkOutput("sat_mp_cnt", 32'(mp_cnt), 32'd15);

    // clear_stats beats an accepted branch in the same cycle.
    clear_stats = 1'b1;
    applyStimulus(mk(6'b000100, 5'd0, 16'h0002), 32'h00000200, 32'd4, 32'd5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    clear_stats = 1'b0;
    checkOutput("clr_ovr_res_valid", 32'(res_valid), 32'h1);
    checkOutput("clr_ovr_br_cnt", 32'(br_cnt), 32'h0);
    checkOutput("clr_ovr_mp_cnt", 32'(mp_cnt), 32'h0);

    // Mid-operation reset discards that cycle's branch.
    rst_n = 1'b0;
    applyStimulus(mk(6'b000100, 5'd0, 16'h0004), 32'h00000040, 32'd1, 32'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("midrst_target", target, 32'h0);
    checkOutput("midrst_br_cnt", 32'(br_cnt), 32'h0);

    // History table at pc 0x40 (index 0): three taken, then two not-taken.
    // The lookup in the updating cycle must show the old counter.
    lookup_pc = 32'h00000040;
    bht_model = 2'b01;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(mk(6'b000100, 5'd0, 16'h0004), 32'h00000040, 32'd1,
                    (t < 3) ? 32'd1 : 32'd2, 1'b0);
      #1;
      checkOutput($sformatf("bht_step%0d_pred", t), 32'(pred_taken), 32'(bht_model[1]));
      @(posedge clk);
      @(negedge clk);
      if (t < 3) bht_model = (bht_model == 2'b11) ? 2'b11 : bht_model + 2'b01;
      else       bht_model = (bht_model == 2'b00) ? 2'b00 : bht_model - 2'b01;
    end
    valid_in = 1'b0;
    checkOutput("bht_after_nt_pred", 32'(pred_taken), 32'h0);
    lookup_pc = 32'h00000044;
    #1;
    checkOutput("bht_other_index_pred", 32'(pred_taken), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution unit for the MIPS datapath, successor to the combinational branch comparator. It evaluates BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ/BLTZAL/BGEZAL with signed compares, computes the branch target and link address, and registers the outcome for the redirect logic. It also holds a 2-bit saturating branch history table (BHT) that serves the fetch stage, and saturating statistics counters. It sits at the ID/EX boundary, with its lookup port feeding IF.

## Interface
- WIDTH, 32, data and address width (≥16).
- BHT_DEPTH, 16, number of BHT entries; power of two, ≥2.
- CNT_W, 16, width of the statistics counters.

- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- lookup_pc  in  WIDTH  fetch PC for the prediction lookup.
- pred_taken  out  1  combinational prediction for lookup_pc.
- valid_in  in  1  a branch candidate is presented this cycle.
- ins  in  32  instruction word: op = ins[31:26], rt = ins[20:16], imm = ins[15:0].
- pc  in  WIDTH  address of the branch instruction.
- din_a, din_b  in  WIDTH  rs and rt operand values (already forwarded).
- pred_in  in  1  prediction made at fetch for this branch.
- stall  in  1  hold all registers; no table or counter update.
- flush  in  1  kill the current input (wrong path).
- clear_stats  in  1  zero both statistics counters.
- res_valid  out  1  registered: resolved branch outputs are valid.
- branch  out  1  registered: branch taken.
- target  out  WIDTH  registered branch target.
- link  out  1  registered: write link_addr to $31.
- link_addr  out  WIDTH  registered pc+8.
- mispredict  out  1  registered: pred_in differed from branch.
- redirect_pc  out  WIDTH  registered: target if taken, else pc+8.
- br_cnt, mp_cnt  out  CNT_W  resolved branches and mispredictions.

## Operation
- **Decode.** A branch is one of:
  - op 000100 BEQ (a==b)
  - op 000101 BNE (a!=b)
  - op 000111 BGTZ (a>0)
  - op 000110 BLEZ (a<=0)
  - op 000001 with rt 00000 BLTZ (a<0)
  - op 000001 with rt 00001 BGEZ (a>=0)
  - op 000001 with rt 10000 BLTZAL (a<0, link)
  - op 000001 with rt 10001 BGEZAL (a>=0, link)
- All magnitude compares treat din_a as signed two's complement WIDTH bits.
- Any other op, or any other rt under op 000001, is not a branch.
- **Accept** = rst_n & valid_in & is_branch & ~stall & ~flush.
- **Target** = pc + 4 + (sign-extended imm << 2), taken modulo 2^WIDTH; link_addr = pc + 8 modulo 2^WIDTH.
- **link** = 1 for BLTZAL/BGEZAL whether or not the branch is taken.
- **BHT indexing.** Index = addr[log2(BHT_DEPTH)+1:2].
  - pred_taken = bit 1 of entry[lookup_pc index].
  - Reset sets every entry to 01 (weakly not-taken).
- **BHT update** on accept, at entry[pc index]: taken increments, saturating at 11; not-taken decrements, saturating at 00.
- **Counters.** On accept, br_cnt += 1; if also mispredicting, mp_cnt += 1. Both saturate at all-ones.
  - clear_stats zeroes both and overrides an increment in the same cycle.
- **Priority:** reset > flush > stall > normal.
  - flush: res_valid <= 0 and no update, even if stall is high.
  - stall (no flush): all output registers, the BHT and the counters hold.
  - valid_in with a non-branch (not stalled, not flushed): res_valid <= 0, no update.
- **Reset values.** res_valid, branch, link and mispredict are 0. target, link_addr and redirect_pc are 0. br_cnt and mp_cnt are 0. All BHT entries are 01.

## Timing
- Resolution latency is one cycle: inputs accepted at edge N appear on the registered outputs after edge N.
- res_valid is a one-cycle pulse per accepted branch, unless stall holds it.
- Back-to-back branches are accepted every cycle with no bubble.
- pred_taken is combinational and has zero latency.
- A lookup and an update to the same index in the same cycle: pred_taken shows the pre-update value. The new value is visible from the next cycle. No bypass.
- The BHT update and counter increment take effect at the same edge that loads the output registers.
- Reset mid-operation: on the edge with rst_n=0, all state returns to its reset value, and that cycle's input is discarded.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles with valid_in=1 (BEQ) -> all outputs 0, and pred_taken=0 for every lookup_pc.
- **BEQ taken.** pc=0x00400010, imm=0xFFFC, din_a=din_b=5, pred_in=0 -> next cycle:
  - res_valid=1, branch=1, target=0x00400004, redirect_pc=0x00400004
  - mispredict=1, br_cnt=1, mp_cnt=1
- **Signed compare.** BGTZ with din_a=0x80000000 -> branch=0, redirect_pc=pc+8. BLTZAL with din_a=0xFFFFFFFF -> branch=1, link=1, link_addr=pc+8.
- **BHT saturation.** Three taken branches at pc=0x40 -> entry index 0 reads 11. Then two not-taken -> reads 01. Same-cycle lookup of 0x40 during an update returns the old value.
- **Stall/flush.** Hold stall=1 for 3 cycles after a result -> outputs and counters frozen. Assert flush together with stall and a valid BNE -> res_valid=0 next cycle, br_cnt unchanged.
- **Boundaries.**
  - pc=0xFFFFFFF8 -> link_addr=0x00000000 (wrap).
  - With CNT_W=4, 17 branches -> br_cnt=15.
  - Undefined REGIMM rt=00010 -> res_valid=0.
